// File: rtl/parking_gate_controller_if.sv
// Lane-side signal bundle between the gate hardware (loops, card readers,
// ParkingSystem vacancy flags) and the parking gate controller.
interface parking_gate_controller_if;

    // Lane and vacancy inputs to the controller
    logic entry_request;
    logic entry_is_uni;
    logic entry_pass;
    logic exit_request;
    logic exit_is_uni;
    logic exit_pass;
    logic uni_is_vacated_space;
    logic is_vacated_space;

    // Event and barrier outputs from the controller
    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;
    logic entry_barrier_up;
    logic exit_barrier_up;
    logic entry_denied;

    // Lane hardware side: drives requests, observes events and barriers
    modport master (
        output entry_request, entry_is_uni, entry_pass,
        output exit_request, exit_is_uni, exit_pass,
        output uni_is_vacated_space, is_vacated_space,
        input  car_entered, is_uni_car_entered,
        input  car_exited, is_uni_car_exited,
        input  entry_barrier_up, exit_barrier_up, entry_denied
    );

    // Controller side
    modport slave (
        input  entry_request, entry_is_uni, entry_pass,
        input  exit_request, exit_is_uni, exit_pass,
        input  uni_is_vacated_space, is_vacated_space,
        output car_entered, is_uni_car_entered,
        output car_exited, is_uni_car_exited,
        output entry_barrier_up, exit_barrier_up, entry_denied
    );

endinterface

// File: rtl/parking_gate_controller.sv
// Parking gate controller: one entry lane and one exit lane, each with its own
// barrier FSM. Every car that physically clears a barrier produces exactly one
// single-cycle event pulse towards the ParkingSystem. Entry checks the vacancy
// flag matching the car class before opening; an unanswered barrier closes
// after BARRIER_TIMEOUT cycles with no event. When both lanes commit together
// the exit event goes first and the entry event follows one cycle later.
module parking_gate_controller #(
    parameter int unsigned BARRIER_TIMEOUT = 16   // legal range 2..1023
) (
    input logic                      clk,
    input logic                      rst_n,
    parking_gate_controller_if.slave gate
);

    localparam int unsigned      CNT_W    = (BARRIER_TIMEOUT > 2) ? $clog2(BARRIER_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BARRIER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        E_IDLE,
        E_CHECK,
        E_OPEN,
        E_COMMIT,
        E_DENY,
        E_RELEASE
    } entry_state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_OPEN,
        X_COMMIT,
        X_RELEASE
    } exit_state_t;

    entry_state_t     entry_state, entry_next;
    exit_state_t      exit_state,  exit_next;

    logic [CNT_W-1:0] entry_cnt;
    logic [CNT_W-1:0] exit_cnt;
    logic             entry_cls;       // class latched at entry request
    logic             exit_cls;        // class latched at exit request
    logic             entry_cls_held;  // class of the last emitted entry event
    logic             exit_cls_held;   // class of the last emitted exit event

    logic             entry_up;
    logic             entry_fire;
    logic             entry_deny;
    logic             exit_up;
    logic             exit_fire;

    // ------------------------------------------------------------------
    // Entry lane
    // ------------------------------------------------------------------

    // Entry FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) entry_state <= E_IDLE;
        else        entry_state <= entry_next;
    end

    // Entry next-state and Moore outputs
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case statement can infer a latch.
        entry_next = entry_state;
        entry_up   = 1'b0;
        entry_fire = 1'b0;
        entry_deny = 1'b0;
        case (entry_state)
            E_IDLE: begin
                if (gate.entry_request) entry_next = E_CHECK;
            end
            E_CHECK: begin
                // Vacancy is sampled only here; later flag changes are ignored
                if (entry_cls ? gate.uni_is_vacated_space : gate.is_vacated_space)
                    entry_next = E_OPEN;
                else
                    entry_next = E_DENY;
            end
            E_OPEN: begin
                entry_up = 1'b1;
                if (gate.entry_pass)         entry_next = E_COMMIT;
                else if (entry_cnt == CNT_LAST) entry_next = E_RELEASE;
            end
            E_COMMIT: begin
                entry_up = 1'b1;
                // Yield to a simultaneous exit commit and pulse one cycle later
                if (exit_state != X_COMMIT) begin
                    entry_fire = 1'b1;
                    entry_next = E_RELEASE;
                end
            end
            E_DENY: begin
                entry_deny = 1'b1;
                entry_next = E_RELEASE;
            end
            E_RELEASE: begin
                // A held request must be dropped before the lane re-arms
                if (!gate.entry_request && !gate.entry_pass) entry_next = E_IDLE;
            end
            default: entry_next = E_IDLE;
        endcase
    end

    // Entry class latch and open-time counter (counter is zero on OPEN entry)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_cls <= 1'b0;
            entry_cnt <= '0;
        end else begin
            if (entry_state == E_IDLE && gate.entry_request)
                entry_cls <= gate.entry_is_uni;
            if (entry_state == E_OPEN) entry_cnt <= entry_cnt + 1'b1;
            else                       entry_cnt <= '0;
        end
    end

    // Entry event class holder: keeps the last emitted class between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          entry_cls_held <= 1'b0;
        else if (entry_fire) entry_cls_held <= entry_cls;
    end

    // ------------------------------------------------------------------
    // Exit lane
    // ------------------------------------------------------------------

    // Exit FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) exit_state <= X_IDLE;
        else        exit_state <= exit_next;
    end

    // Exit next-state and Moore outputs
    always_comb begin
        exit_next = exit_state;
        exit_up   = 1'b0;
        exit_fire = 1'b0;
        case (exit_state)
            X_IDLE: begin
                if (gate.exit_request) exit_next = X_OPEN;
            end
            X_OPEN: begin
                exit_up = 1'b1;
                if (gate.exit_pass)            exit_next = X_COMMIT;
                else if (exit_cnt == CNT_LAST) exit_next = X_RELEASE;
            end
            X_COMMIT: begin
                // Exit always wins a simultaneous commit
                exit_up   = 1'b1;
                exit_fire = 1'b1;
                exit_next = X_RELEASE;
            end
            X_RELEASE: begin
                if (!gate.exit_request && !gate.exit_pass) exit_next = X_IDLE;
            end
            default: exit_next = X_IDLE;
        endcase
    end

    // Exit class latch and open-time counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exit_cls <= 1'b0;
            exit_cnt <= '0;
        end else begin
            if (exit_state == X_IDLE && gate.exit_request)
                exit_cls <= gate.exit_is_uni;
            if (exit_state == X_OPEN) exit_cnt <= exit_cnt + 1'b1;
            else                      exit_cnt <= '0;
        end
    end

    // Exit event class holder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         exit_cls_held <= 1'b0;
        else if (exit_fire) exit_cls_held <= exit_cls;
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state, so an async reset drops them at once
    // ------------------------------------------------------------------
    assign gate.entry_barrier_up   = entry_up;
    assign gate.entry_denied       = entry_deny;
    assign gate.car_entered        = entry_fire;
    assign gate.is_uni_car_entered = entry_fire ? entry_cls : entry_cls_held;

    assign gate.exit_barrier_up    = exit_up;
    assign gate.car_exited         = exit_fire;
    assign gate.is_uni_car_exited  = exit_fire ? exit_cls : exit_cls_held;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed testbench for parking_gate_controller (BARRIER_TIMEOUT = 16).
// Inputs change and outputs are sampled 1 time unit after each rising edge;
// "cycle 0" of a scenario is the cycle in which its first request is driven.
module tb_parking_gate_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    parking_gate_controller_if gate_if ();

    parking_gate_controller #(
        .BARRIER_TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .gate (gate_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        gate_if.entry_request        = 1'b0;
        gate_if.entry_is_uni         = 1'b0;
        gate_if.entry_pass           = 1'b0;
        gate_if.exit_request         = 1'b0;
        gate_if.exit_is_uni          = 1'b0;
        gate_if.exit_pass            = 1'b0;
        gate_if.uni_is_vacated_space = 1'b0;
        gate_if.is_vacated_space     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gate_if.car_entered !== 1'b0) begin errors++; $display("FAIL reset car_entered: got %b want 0", gate_if.car_entered); end
        checks++;
        if (gate_if.is_uni_car_entered !== 1'b0) begin errors++; $display("FAIL reset is_uni_car_entered: got %b want 0", gate_if.is_uni_car_entered); end
        checks++;
        if (gate_if.car_exited !== 1'b0) begin errors++; $display("FAIL reset car_exited: got %b want 0", gate_if.car_exited); end
        checks++;
        if (gate_if.is_uni_car_exited !== 1'b0) begin errors++; $display("FAIL reset is_uni_car_exited: got %b want 0", gate_if.is_uni_car_exited); end
        checks++;
        if (gate_if.entry_barrier_up !== 1'b0) begin errors++; $display("FAIL reset entry_barrier_up: got %b want 0", gate_if.entry_barrier_up); end
        checks++;
        if (gate_if.exit_barrier_up !== 1'b0) begin errors++; $display("FAIL reset exit_barrier_up: got %b want 0", gate_if.exit_barrier_up); end
        checks++;
        if (gate_if.entry_denied !== 1'b0) begin errors++; $display("FAIL reset entry_denied: got %b want 0", gate_if.entry_denied); end
        rst_n = 1'b1;
        step();
    endtask

    // University car admitted; pass at cycle 5; request held throughout
    task automatic test_entry_admit();
        int   pulses;
        logic exp_up;
        logic exp_ent;
        pulses = 0;
        gate_if.entry_is_uni         = 1'b1;
        gate_if.uni_is_vacated_space = 1'b1;
        gate_if.is_vacated_space     = 1'b0;
        for (int cyc = 0; cyc <= 12; cyc++) begin
            gate_if.entry_request = 1'b1;
            gate_if.entry_pass    = (cyc == 5);
            exp_up  = (cyc >= 2 && cyc <= 6);
            exp_ent = (cyc == 6);
            if (gate_if.car_entered === 1'b1) pulses++;
            checks++;
            if (gate_if.entry_barrier_up !== exp_up) begin errors++; $display("FAIL admit barrier cyc %0d: got %b want %b", cyc, gate_if.entry_barrier_up, exp_up); end
            checks++;
            if (gate_if.car_entered !== exp_ent) begin errors++; $display("FAIL admit car_entered cyc %0d: got %b want %b", cyc, gate_if.car_entered, exp_ent); end
            if (cyc == 6) begin
                checks++;
                if (gate_if.is_uni_car_entered !== 1'b1) begin errors++; $display("FAIL admit class: got %b want 1", gate_if.is_uni_car_entered); end
            end
            step();
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL admit pulse count: got %0d want 1", pulses); end
        gate_if.entry_request = 1'b0;
        gate_if.entry_pass    = 1'b0;
        step();
        step();
    endtask

    // Refusals: general car with no general space, uni car with no uni space
    task automatic test_entry_deny();
        logic exp_den;
        for (int v = 0; v < 2; v++) begin
            gate_if.entry_is_uni         = (v == 1);
            gate_if.uni_is_vacated_space = (v == 0);
            gate_if.is_vacated_space     = (v == 1);
            for (int cyc = 0; cyc <= 6; cyc++) begin
                gate_if.entry_request = 1'b1;
                exp_den = (cyc == 2);
                checks++;
                if (gate_if.entry_denied !== exp_den) begin errors++; $display("FAIL deny v%0d denied cyc %0d: got %b want %b", v, cyc, gate_if.entry_denied, exp_den); end
                checks++;
                if (gate_if.entry_barrier_up !== 1'b0) begin errors++; $display("FAIL deny v%0d barrier cyc %0d: got %b want 0", v, cyc, gate_if.entry_barrier_up); end
                checks++;
                if (gate_if.car_entered !== 1'b0) begin errors++; $display("FAIL deny v%0d car_entered cyc %0d: got %b want 0", v, cyc, gate_if.car_entered); end
                step();
            end
            gate_if.entry_request = 1'b0;
            step();
            step();
        end
    endtask

    // Exit opened with no pass: barrier up for exactly 16 cycles, no event
    task automatic test_exit_timeout();
        logic exp_up;
        gate_if.exit_is_uni = 1'b1;
        for (int cyc = 0; cyc <= 21; cyc++) begin
            gate_if.exit_request = 1'b1;
            gate_if.exit_pass    = 1'b0;
            exp_up = (cyc >= 1 && cyc <= 16);
            checks++;
            if (gate_if.exit_barrier_up !== exp_up) begin errors++; $display("FAIL timeout barrier cyc %0d: got %b want %b", cyc, gate_if.exit_barrier_up, exp_up); end
            checks++;
            if (gate_if.car_exited !== 1'b0) begin errors++; $display("FAIL timeout car_exited cyc %0d: got %b want 0", cyc, gate_if.car_exited); end
            step();
        end
        gate_if.exit_request = 1'b0;
        step();
        step();
    endtask

    // Both lanes commit together: exit pulses at 5, entry at 6
    task automatic test_simultaneous();
        logic exp_ent;
        logic exp_ext;
        logic exp_eup;
        logic exp_xup;
        gate_if.is_vacated_space     = 1'b1;
        gate_if.uni_is_vacated_space = 1'b0;
        gate_if.entry_is_uni         = 1'b0;
        gate_if.exit_is_uni          = 1'b1;
        for (int cyc = 0; cyc <= 9; cyc++) begin
            gate_if.entry_request = 1'b1;
            gate_if.exit_request  = (cyc >= 1);
            if (cyc >= 2) begin
                // Flip class inputs after both were latched
                gate_if.entry_is_uni = 1'b1;
                gate_if.exit_is_uni  = 1'b0;
            end
            gate_if.entry_pass = (cyc == 4);
            gate_if.exit_pass  = (cyc == 4);
            exp_ext = (cyc == 5);
            exp_ent = (cyc == 6);
            exp_eup = (cyc >= 2 && cyc <= 6);
            exp_xup = (cyc >= 2 && cyc <= 5);
            checks++;
            if (gate_if.car_exited !== exp_ext) begin errors++; $display("FAIL simul car_exited cyc %0d: got %b want %b", cyc, gate_if.car_exited, exp_ext); end
            checks++;
            if (gate_if.car_entered !== exp_ent) begin errors++; $display("FAIL simul car_entered cyc %0d: got %b want %b", cyc, gate_if.car_entered, exp_ent); end
            checks++;
            if (gate_if.entry_barrier_up !== exp_eup) begin errors++; $display("FAIL simul entry barrier cyc %0d: got %b want %b", cyc, gate_if.entry_barrier_up, exp_eup); end
            checks++;
            if (gate_if.exit_barrier_up !== exp_xup) begin errors++; $display("FAIL simul exit barrier cyc %0d: got %b want %b", cyc, gate_if.exit_barrier_up, exp_xup); end
            if (cyc == 5) begin
                checks++;
                if (gate_if.is_uni_car_exited !== 1'b1) begin errors++; $display("FAIL simul exit class: got %b want 1", gate_if.is_uni_car_exited); end
            end
            if (cyc == 6) begin
                checks++;
                if (gate_if.is_uni_car_entered !== 1'b0) begin errors++; $display("FAIL simul entry class: got %b want 0", gate_if.is_uni_car_entered); end
            end
            if (cyc == 8) begin
                checks++;
                if (gate_if.is_uni_car_exited !== 1'b1) begin errors++; $display("FAIL simul exit class hold: got %b want 1", gate_if.is_uni_car_exited); end
            end
            step();
        end
        gate_if.entry_request = 1'b0;
        gate_if.exit_request  = 1'b0;
        gate_if.entry_pass    = 1'b0;
        gate_if.exit_pass     = 1'b0;
        step();
        step();
    endtask

    // Async reset while entry is OPEN, tailgate after release, clean restart
    task automatic test_reset_mid_open();
        logic exp_up;
        gate_if.entry_is_uni     = 1'b0;
        gate_if.is_vacated_space = 1'b1;
        gate_if.entry_request    = 1'b1;
        step();
        step();
        step();
        checks++;
        if (gate_if.entry_barrier_up !== 1'b1) begin errors++; $display("FAIL rstmid barrier before reset: got %b want 1", gate_if.entry_barrier_up); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gate_if.entry_barrier_up !== 1'b0) begin errors++; $display("FAIL rstmid barrier during reset: got %b want 0", gate_if.entry_barrier_up); end
        gate_if.entry_request = 1'b0;
        gate_if.entry_pass    = 1'b1;
        step();
        rst_n = 1'b1;
        for (int cyc = 0; cyc <= 4; cyc++) begin
            checks++;
            if (gate_if.car_entered !== 1'b0) begin errors++; $display("FAIL rstmid tailgate car_entered cyc %0d: got %b want 0", cyc, gate_if.car_entered); end
            checks++;
            if (gate_if.entry_barrier_up !== 1'b0) begin errors++; $display("FAIL rstmid tailgate barrier cyc %0d: got %b want 0", cyc, gate_if.entry_barrier_up); end
            step();
        end
        gate_if.entry_pass = 1'b0;
        for (int cyc = 0; cyc <= 4; cyc++) begin
            gate_if.entry_request = 1'b1;
            gate_if.entry_pass    = (cyc == 2);
            exp_up = (cyc >= 2 && cyc <= 3);
            checks++;
            if (gate_if.entry_barrier_up !== exp_up) begin errors++; $display("FAIL rstmid restart barrier cyc %0d: got %b want %b", cyc, gate_if.entry_barrier_up, exp_up); end
            checks++;
            if (gate_if.car_entered !== (cyc == 3)) begin errors++; $display("FAIL rstmid restart car_entered cyc %0d: got %b want %b", cyc, gate_if.car_entered, (cyc == 3)); end
            if (cyc == 3) begin
                checks++;
                if (gate_if.is_uni_car_entered !== 1'b0) begin errors++; $display("FAIL rstmid restart class: got %b want 0", gate_if.is_uni_car_entered); end
            end
            step();
        end
        gate_if.entry_request = 1'b0;
        gate_if.entry_pass    = 1'b0;
        step();
        step();
    endtask

    // 50 exit cars back to back, class alternating 1,0,1,...
    task automatic test_back_to_back();
        int   pulses;
        logic cls;
        pulses = 0;
        for (int car = 0; car < 50; car++) begin
            cls = (car % 2 == 0);
            // cycle 0: request with class
            gate_if.exit_request = 1'b1;
            gate_if.exit_is_uni  = cls;
            gate_if.exit_pass    = 1'b0;
            if (gate_if.car_exited === 1'b1) pulses++;
            step();
            // cycle 1: barrier up, car passes, class input flips
            gate_if.exit_request = 1'b0;
            gate_if.exit_is_uni  = ~cls;
            gate_if.exit_pass    = 1'b1;
            checks++;
            if (gate_if.exit_barrier_up !== 1'b1) begin errors++; $display("FAIL b2b car %0d barrier: got %b want 1", car, gate_if.exit_barrier_up); end
            if (gate_if.car_exited === 1'b1) pulses++;
            step();
            // cycle 2: event pulse with latched class
            gate_if.exit_pass = 1'b0;
            checks++;
            if (gate_if.car_exited !== 1'b1) begin errors++; $display("FAIL b2b car %0d car_exited: got %b want 1", car, gate_if.car_exited); end
            checks++;
            if (gate_if.is_uni_car_exited !== cls) begin errors++; $display("FAIL b2b car %0d class: got %b want %b", car, gate_if.is_uni_car_exited, cls); end
            if (gate_if.car_exited === 1'b1) pulses++;
            step();
            // cycle 3: release, back to idle
            if (gate_if.car_exited === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses != 50) begin errors++; $display("FAIL b2b pulse count: got %0d want 50", pulses); end
    endtask

    // Entry and exit events must never be high in the same cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (gate_if.car_entered === 1'b1 && gate_if.car_exited === 1'b1) begin
                errors++;
                $display("FAIL overlap: car_entered=%b car_exited=%b want not both 1", gate_if.car_entered, gate_if.car_exited);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive_idle();
        test_reset();
        test_entry_admit();
        test_entry_deny();
        test_exit_timeout();
        test_simultaneous();
        test_reset_mid_open();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
